conv_frame_ctrl: RTL and testbench
==================================

Name: conv_frame_ctrl

Overview:
- Frame sequencer that sits between a streaming pixel source and the sliding-window image buffer.
- Accepts exactly imageWidth*imageHeight pixels per frame over a valid/ready handshake and pushes them into the window buffer.
- After the last pixel, injects padding pixels so the buffer drains the final windows.
- Emits a window-valid strobe tagged with centre row/column and a border flag, and pulses done at end of frame.

Parameters:
- dataWidth, 8, pixel width in bits
- imageWidth, 512, pixels per row
- imageHeight, 512, rows per frame
- kernelWidth, 3, window width (odd)
- kernelHeight, 3, window height (odd)
- padValue, 0, pixel value injected during flush

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle frame start request; ignored unless IDLE
- i_abort  in  1  synchronous frame abort
- i_s_data  in  dataWidth  source pixel
- i_s_valid  in  1  source pixel valid
- o_s_ready  out  1  controller accepts pixel
- o_buf_pixel_data  out  dataWidth  pixel to window buffer (registered)
- o_buf_pixel_valid  out  1  push strobe to window buffer (registered)
- o_win_valid  out  1  buffer window output is a valid centred window this cycle
- o_win_row  out  $clog2(imageHeight)  centre row of current window
- o_win_col  out  $clog2(imageWidth)  centre column of current window
- o_win_border  out  1  window overlaps image edge; its contents include wrapped or pad pixels
- o_busy  out  1  state != IDLE
- o_frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Derived constants:
  - hw = (kernelWidth-1)/2
  - hh = (kernelHeight-1)/2
  - PAD = hh*imageWidth + hw
  - NPIX = imageWidth*imageHeight
- Reset (async, i_reset_n=0):
  - state=IDLE; all counters 0; every output 0.
  - Takes effect immediately mid-frame; no done pulse is produced.
- States:
  - IDLE:
    - o_s_ready=0, no pushes.
    - i_start=1 -> STREAM; clears inCount, pushCount, row, col.
  - STREAM:
    - o_s_ready=1 combinationally.
    - Accept = i_s_valid & o_s_ready. Each accept registers i_s_data into o_buf_pixel_data with o_buf_pixel_valid=1 next cycle; otherwise o_buf_pixel_valid=0 and data holds.
    - inCount increments per accept.
    - Accept with inCount==NPIX-1 -> FLUSH if PAD>0, else DONE.
  - FLUSH:
    - o_s_ready=0.
    - Pushes padValue every cycle for exactly PAD cycles (flushCount 0..PAD-1), then -> DONE.
  - DONE:
    - o_frame_done=1 for this one cycle; -> IDLE.
- Push index p counts every buffer push in the frame (0..NPIX+PAD-1).
- Window tagging:
  - o_win_valid is asserted one cycle after an o_buf_pixel_valid whose p >= PAD. This matches the buffer's one-cycle register stage.
  - Exactly NPIX windows per frame.
  - Window n (n = p-PAD) has centre row = n / imageWidth and col = n % imageWidth.
  - Row and col are kept as wrap counters: col wraps imageWidth-1 -> 0 and increments row. Never divide.
  - o_win_border = (row<hh) | (row>=imageHeight-hh) | (col<hw) | (col>=imageWidth-hw).
  - Row, col and border are valid only while o_win_valid=1; otherwise they hold their last value.
- i_abort (any non-IDLE state):
  - Next state IDLE; counters cleared; pending o_buf_pixel_valid and o_win_valid deasserted next cycle; no o_frame_done.
  - i_abort has priority over a simultaneous last-pixel accept.
- i_start while busy is ignored. i_start and i_abort together in IDLE: abort wins, stay IDLE.
- Source stalls (i_s_valid=0) in STREAM insert gaps in pushes; window tagging follows pushes, not cycles.
- o_frame_done is asserted in the cycle after the last flush push. The final o_win_valid coincides with it.
- Widths: inCount $clog2(NPIX+1); pushCount $clog2(NPIX+PAD+1); all arithmetic unsigned.

Test Plan:
- Basic frame:
  - Stimulus: imageWidth=8, imageHeight=4, 3x3, continuous valid, pixel value=index.
  - Required: 32 accepts; 9 pad pushes (PAD=9); 41 total pushes; 32 o_win_valid.
  - First window at (row0, col0), border=1. Window (1,1) border=0. Last window (3,7). o_frame_done one cycle after final push, then o_busy=0.
- Backpressure gaps:
  - Stimulus: same frame, i_s_valid toggling 1/0.
  - Required: identical push data sequence and window row/col sequence; done only after 32 accepts plus 9 flush cycles.
- Abort:
  - Stimulus: i_abort after 20 accepts.
  - Required: IDLE next cycle, o_s_ready=0, no further pushes or windows, no done pulse. A following i_start runs a clean full frame from (0,0).
- Async reset mid-FLUSH:
  - Stimulus: i_reset_n low during FLUSH.
  - Required: all outputs 0 immediately, state IDLE, no done pulse.
- Ignored start and 1x1 kernel:
  - Stimulus: i_start during STREAM; then a frame with kernelWidth=kernelHeight=1 (PAD=0).
  - Required: i_start during STREAM has no effect. With PAD=0, STREAM goes directly to DONE, all 32 windows have border=0, and o_win_valid follows each push by one cycle.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer between a streaming pixel source and a sliding-window buffer.
// Streams one frame of pixels, flushes with pad pixels, and tags centred windows.
module conv_frame_ctrl #(
   parameter int dataWidth    = 8,
   parameter int imageWidth   = 512,
   parameter int imageHeight  = 512,
   parameter int kernelWidth  = 3,
   parameter int kernelHeight = 3,
   parameter int padValue     = 0
) (
   input  logic                           i_clk,
   input  logic                           i_reset_n,
   input  logic                           i_start,
   input  logic                           i_abort,
   input  logic [dataWidth-1:0]           i_s_data,
   input  logic                           i_s_valid,
   output logic                           o_s_ready,
   output logic [dataWidth-1:0]           o_buf_pixel_data,
   output logic                           o_buf_pixel_valid,
   output logic                           o_win_valid,
   output logic [$clog2(imageHeight)-1:0] o_win_row,
   output logic [$clog2(imageWidth)-1:0]  o_win_col,
   output logic                           o_win_border,
   output logic                           o_busy,
   output logic                           o_frame_done
);

   localparam int HW    = (kernelWidth - 1) / 2;
   localparam int HH    = (kernelHeight - 1) / 2;
   localparam int PAD   = HH * imageWidth + HW;
   localparam int NPIX  = imageWidth * imageHeight;
   localparam int IN_W  = $clog2(NPIX + 1);
   localparam int PC_W  = $clog2(NPIX + PAD + 1);
   localparam int FL_W  = (PAD > 1) ? $clog2(PAD) : 1;
   localparam int ROW_W = $clog2(imageHeight);
   localparam int COL_W = $clog2(imageWidth);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t               state, state_n;
   logic [IN_W-1:0]      in_cnt;
   logic [PC_W-1:0]      push_cnt;
   logic [FL_W-1:0]      flush_cnt;
   logic [ROW_W-1:0]     nxt_row;
   logic [COL_W-1:0]     nxt_col;
   logic                 nxt_border;
   logic                 win_pend;
   logic                 accept;
   logic                 abort_eff;
   logic                 push;
   logic                 past_pad;
   logic                 win_load;
   logic                 done_n;
   logic [dataWidth-1:0] push_data;

   assign o_s_ready = (state == S_STREAM);
   assign o_busy    = (state != S_IDLE);
   assign accept    = i_s_valid & o_s_ready;
   assign abort_eff = i_abort & (state != S_IDLE);
   // int casts keep the comparisons signed so zero-sized margins stay lint-quiet
   assign past_pad  = (int'(push_cnt) >= PAD);
   assign win_load  = o_buf_pixel_valid & win_pend & ~abort_eff;

   assign nxt_border = (int'(nxt_row) < HH) || (int'(nxt_row) >= imageHeight - HH) ||
                       (int'(nxt_col) < HW) || (int'(nxt_col) >= imageWidth - HW);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      push      = 1'b0;
      push_data = i_s_data;
      done_n    = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_start && !i_abort) state_n = S_STREAM;
         end
         S_STREAM: begin
            if (i_abort) begin
               state_n = S_IDLE;
            end else if (accept) begin
               push = 1'b1;
               if (in_cnt == IN_W'(NPIX - 1)) state_n = (PAD > 0) ? S_FLUSH : S_DONE;
            end
         end
         S_FLUSH: begin
            if (i_abort) begin
               state_n = S_IDLE;
            end else begin
               push      = 1'b1;
               push_data = dataWidth'(padValue);
               if (flush_cnt == FL_W'(PAD - 1)) state_n = S_DONE;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            done_n  = ~i_abort;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Frame counters; idle or abort holds them cleared so a start begins at zero.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         in_cnt    <= '0;
         push_cnt  <= '0;
         flush_cnt <= '0;
         nxt_row   <= '0;
         nxt_col   <= '0;
      end else if (abort_eff || state == S_IDLE) begin
         in_cnt    <= '0;
         push_cnt  <= '0;
         flush_cnt <= '0;
         nxt_row   <= '0;
         nxt_col   <= '0;
      end else begin
         if (accept) in_cnt <= in_cnt + IN_W'(1);
         if (push) push_cnt <= push_cnt + PC_W'(1);
         if (state == S_FLUSH) flush_cnt <= flush_cnt + FL_W'(1);
         if (win_load) begin
            if (nxt_col == COL_W'(imageWidth - 1)) begin
               nxt_col <= '0;
               nxt_row <= (nxt_row == ROW_W'(imageHeight - 1)) ? '0 : nxt_row + ROW_W'(1);
            end else begin
               nxt_col <= nxt_col + COL_W'(1);
            end
         end
      end
   end

   // Window strobe trails the push by one cycle to match the buffer's register stage.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_buf_pixel_data  <= '0;
         o_buf_pixel_valid <= 1'b0;
         win_pend          <= 1'b0;
         o_win_valid       <= 1'b0;
         o_win_row         <= '0;
         o_win_col         <= '0;
         o_win_border      <= 1'b0;
         o_frame_done      <= 1'b0;
      end else begin
         o_buf_pixel_valid <= push;
         if (push) o_buf_pixel_data <= push_data;
         win_pend     <= push & past_pad;
         o_win_valid  <= win_load;
         if (win_load) begin
            o_win_row    <= nxt_row;
            o_win_col    <= nxt_col;
            o_win_border <= nxt_border;
         end
         o_frame_done <= done_n;
      end
   end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Randomized bench for conv_frame_ctrl: 8x4 frame with a 3x3 instance and a 1x1 instance,
// compared against a push/window list computed from the frame rules.
module tb_conv_frame_ctrl;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int NPIX = W * H;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start[2];
   logic       abort[2];
   logic       s_valid[2];
   logic [7:0] s_data[2];
   logic       ready[2];
   logic [7:0] bd[2];
   logic       bv[2];
   logic       wv[2];
   logic [1:0] wr[2];
   logic [2:0] wc[2];
   logic       wb[2];
   logic       busy[2];
   logic       done[2];

   always #5 clk = ~clk;

   conv_frame_ctrl #(.dataWidth(8), .imageWidth(W), .imageHeight(H),
                     .kernelWidth(3), .kernelHeight(3), .padValue(0)) u_k3 (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
      .i_s_data(s_data[0]), .i_s_valid(s_valid[0]), .o_s_ready(ready[0]),
      .o_buf_pixel_data(bd[0]), .o_buf_pixel_valid(bv[0]), .o_win_valid(wv[0]),
      .o_win_row(wr[0]), .o_win_col(wc[0]), .o_win_border(wb[0]),
      .o_busy(busy[0]), .o_frame_done(done[0]));

   conv_frame_ctrl #(.dataWidth(8), .imageWidth(W), .imageHeight(H),
                     .kernelWidth(1), .kernelHeight(1), .padValue(0)) u_k1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
      .i_s_data(s_data[1]), .i_s_valid(s_valid[1]), .o_s_ready(ready[1]),
      .o_buf_pixel_data(bd[1]), .o_buf_pixel_valid(bv[1]), .o_win_valid(wv[1]),
      .o_win_row(wr[1]), .o_win_col(wc[1]), .o_win_border(wb[1]),
      .o_busy(busy[1]), .o_frame_done(done[1]));

   int checks = 0;
   int fails  = 0;
   int passed = 0;

   // monitor state (written only by the monitor process)
   int         cur = 0;
   logic       mon_clr = 1'b0;
   int         cyc = 0;
   logic [7:0] push_q[$];
   logic [5:0] win_q[$];
   logic       win_ok_q[$];
   int         done_cnt = 0;
   int         done_cycle = 0;
   int         pix_last_cycle = 0;
   int         last_win_cycle = 0;
   logic       prev_bv = 1'b0;
   int         prev_idx = 0;

   // reference model state (written only by the stimulus process)
   logic [7:0] exp_pix[$];
   logic [7:0] exp_push[$];
   logic [5:0] exp_win[$];
   int         feed_acc;

   function automatic int pad_of(input int sel);
      return (sel == 0) ? 9 : 0;
   endfunction

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (mon_clr) begin
         push_q.delete();
         win_q.delete();
         win_ok_q.delete();
         done_cnt <= 0;
         prev_bv  <= 1'b0;
         prev_idx <= 0;
      end else begin
         if (wv[cur]) begin
            win_q.push_back({wr[cur], wc[cur], wb[cur]});
            win_ok_q.push_back(prev_bv && prev_idx >= pad_of(cur));
            last_win_cycle <= cyc;
         end
         if (bv[cur]) begin
            push_q.push_back(bd[cur]);
            if (push_q.size() == NPIX) pix_last_cycle <= cyc;
         end
         prev_bv  <= bv[cur];
         prev_idx <= push_q.size() - 1;
         if (done[cur]) begin
            done_cnt   <= done_cnt + 1;
            done_cycle <= cyc;
         end
      end
   end

   task automatic clear_mon(input int sel);
      cur = sel;
      exp_pix.delete();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input int sel);
      start[sel] = 1'b1;
      @(posedge clk);
      #1 start[sel] = 1'b0;
   endtask

   // mode 0: continuous, data = index; 1: valid toggles, random data; 2: random valid and data
   task automatic feed(input int sel, input int n, input int mode, input int start_at);
      int guard = 0;
      feed_acc = 0;
      while (feed_acc < n && guard < 2000) begin
         s_data[sel]  = (mode == 0) ? 8'(feed_acc) : 8'($urandom_range(0, 255));
         s_valid[sel] = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
         start[sel]   = (start_at >= 0 && feed_acc == start_at);
         @(negedge clk);
         if (s_valid[sel] && ready[sel]) begin
            exp_pix.push_back(s_data[sel]);
            feed_acc++;
         end
         @(posedge clk);
         #1 guard++;
      end
      s_valid[sel] = 1'b0;
      start[sel]   = 1'b0;
      checks++;
      if (feed_acc != n) begin
         fails++;
         $display("FAIL feed_accepts: got %0d accepts, want %0d", feed_acc, n);
      end else passed++;
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (done_cnt == 0 && k < limit) begin
         @(posedge clk);
         #1 k++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Expected pushes: accepted pixels then pad zeros; windows: n -> (n/W, n%W, border).
   task automatic build_model(input int sel);
      int hw, hh, r, c;
      logic b;
      hw = (sel == 0) ? 1 : 0;
      hh = hw;
      exp_push.delete();
      exp_win.delete();
      foreach (exp_pix[i]) exp_push.push_back(exp_pix[i]);
      for (int i = 0; i < pad_of(sel); i++) exp_push.push_back(8'd0);
      for (int n = 0; n < NPIX; n++) begin
         r = n / W;
         c = n % W;
         b = (r < hh) || (r >= H - hh) || (c < hw) || (c >= W - hw);
         exp_win.push_back({2'(r), 3'(c), b});
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ({bv[s], wv[s], busy[s], ready[s], done[s], wb[s]} !== 6'b0 || bd[s] !== 8'd0 ||
             wr[s] !== 2'd0 || wc[s] !== 3'd0) begin
            fails++;
            $display("FAIL reset_outputs[%0d]: bv=%b wv=%b busy=%b rdy=%b done=%b bd=%h r=%0d c=%0d b=%b, want all 0",
                     s, bv[s], wv[s], busy[s], ready[s], done[s], bd[s], wr[s], wc[s], wb[s]);
         end else passed++;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b1;
      abort[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      abort[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL start_abort_idle: busy=%b, want 0", busy[0]);
      end else passed++;
   endtask

   task automatic test_basic;
      int bad;
      clear_mon(0);
      start_frame(0);
      checks++;
      if (busy[0] !== 1'b1 || ready[0] !== 1'b1) begin
         fails++;
         $display("FAIL basic_started: busy=%b ready=%b, want 1 1", busy[0], ready[0]);
      end else passed++;
      feed(0, NPIX, 0, -1);
      wait_done(200);
      build_model(0);
      checks++;
      if (push_q.size() != 41) begin
         fails++;
         $display("FAIL basic_push_count: got %0d, want 41", push_q.size());
      end else passed++;
      bad = 0;
      foreach (exp_push[i]) if (i >= push_q.size() || push_q[i] !== exp_push[i]) bad++;
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL basic_push_data: %0d mismatching pushes, want 0", bad);
      end else passed++;
      checks++;
      if (win_q.size() != NPIX) begin
         fails++;
         $display("FAIL basic_win_count: got %0d, want %0d", win_q.size(), NPIX);
      end else passed++;
      bad = 0;
      foreach (exp_win[i]) if (i >= win_q.size() || win_q[i] !== exp_win[i] || !win_ok_q[i]) bad++;
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL basic_windows: %0d bad windows, want 0", bad);
      end else passed++;
      checks++;
      if (win_q.size() != NPIX || win_q[0] !== 6'b00_000_1 || win_q[9] !== 6'b01_001_0 ||
          win_q[31] !== 6'b11_111_1) begin
         fails++;
         $display("FAIL basic_corner_windows: first=%b w9=%b last=%b, want 000001 010010 111111",
                  win_q.size() > 0 ? win_q[0] : 6'bx, win_q.size() > 9 ? win_q[9] : 6'bx,
                  win_q.size() > 31 ? win_q[31] : 6'bx);
      end else passed++;
      checks++;
      if (done_cnt != 1 || done_cycle != pix_last_cycle + 10 || last_win_cycle != done_cycle) begin
         fails++;
         $display("FAIL basic_done: cnt=%0d at cyc %0d lastwin %0d, want 1 at %0d",
                  done_cnt, done_cycle, last_win_cycle, pix_last_cycle + 10);
      end else passed++;
      checks++;
      if (busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL basic_idle_after: busy=%b, want 0", busy[0]);
      end else passed++;
   endtask

   task automatic test_backpressure;
      int bad;
      clear_mon(0);
      start_frame(0);
      feed(0, NPIX, 1, -1);
      wait_done(200);
      build_model(0);
      bad = (push_q.size() != exp_push.size()) ? 1 : 0;
      foreach (exp_push[i]) if (i >= push_q.size() || push_q[i] !== exp_push[i]) bad++;
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL gaps_push_data: %0d bad (got %0d pushes), want 0", bad, push_q.size());
      end else passed++;
      bad = (win_q.size() != NPIX) ? 1 : 0;
      foreach (exp_win[i]) if (i >= win_q.size() || win_q[i] !== exp_win[i] || !win_ok_q[i]) bad++;
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL gaps_windows: %0d bad (got %0d windows), want 0", bad, win_q.size());
      end else passed++;
      checks++;
      if (done_cnt != 1 || done_cycle != pix_last_cycle + 10) begin
         fails++;
         $display("FAIL gaps_done: cnt=%0d at cyc %0d, want 1 at %0d", done_cnt, done_cycle, pix_last_cycle + 10);
      end else passed++;
   endtask

   task automatic test_abort;
      int bad;
      clear_mon(0);
      start_frame(0);
      feed(0, 20, 2, -1);
      abort[0]   = 1'b1;
      s_valid[0] = 1'b1;
      s_data[0]  = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1 abort[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle: busy=%b ready=%b, want 0 0", busy[0], ready[0]);
      end else passed++;
      repeat (12) @(posedge clk);
      #1 s_valid[0] = 1'b0;
      checks++;
      if (push_q.size() != 20 || win_q.size() != 10 || done_cnt != 0) begin
         fails++;
         $display("FAIL abort_quiet: pushes=%0d wins=%0d done=%0d, want 20 10 0",
                  push_q.size(), win_q.size(), done_cnt);
      end else passed++;
      clear_mon(0);
      start_frame(0);
      feed(0, NPIX, 2, -1);
      wait_done(300);
      build_model(0);
      bad = (push_q.size() != exp_push.size()) ? 1 : 0;
      foreach (exp_push[i]) if (i >= push_q.size() || push_q[i] !== exp_push[i]) bad++;
      foreach (exp_win[i]) if (i >= win_q.size() || win_q[i] !== exp_win[i]) bad++;
      checks++;
      if (bad != 0 || win_q.size() != NPIX || done_cnt != 1) begin
         fails++;
         $display("FAIL abort_recover: bad=%0d wins=%0d done=%0d, want 0 %0d 1", bad, win_q.size(), NPIX, done_cnt);
      end else passed++;
   endtask

   task automatic test_reset_flush;
      clear_mon(0);
      start_frame(0);
      feed(0, NPIX, 2, -1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy[0] !== 1'b1 || bv[0] !== 1'b1 || ready[0] !== 1'b0) begin
         fails++;
         $display("FAIL flush_active: busy=%b bv=%b ready=%b, want 1 1 0", busy[0], bv[0], ready[0]);
      end else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bv[0], wv[0], busy[0], ready[0], done[0], wb[0]} !== 6'b0 || bd[0] !== 8'd0 ||
          wr[0] !== 2'd0 || wc[0] !== 3'd0) begin
         fails++;
         $display("FAIL flush_reset_outputs: bv=%b wv=%b busy=%b done=%b r=%0d c=%0d, want all 0",
                  bv[0], wv[0], busy[0], done[0], wr[0], wc[0]);
      end else passed++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (done_cnt != 0 || busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL flush_reset_nodone: done=%0d busy=%b, want 0 0", done_cnt, busy[0]);
      end else passed++;
   endtask

   task automatic test_ignored_start_k1;
      int bad;
      clear_mon(1);
      start_frame(1);
      feed(1, NPIX, 0, 10);
      wait_done(100);
      build_model(1);
      bad = (push_q.size() != NPIX) ? 1 : 0;
      foreach (exp_push[i]) if (i >= push_q.size() || push_q[i] !== exp_push[i]) bad++;
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL k1_push_data: %0d bad (got %0d pushes), want 0", bad, push_q.size());
      end else passed++;
      bad = (win_q.size() != NPIX) ? 1 : 0;
      foreach (exp_win[i]) if (i >= win_q.size() || win_q[i] !== exp_win[i] || !win_ok_q[i] || win_q[i][0]) bad++;
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL k1_windows: %0d bad (got %0d windows), want 0", bad, win_q.size());
      end else passed++;
      checks++;
      if (done_cnt != 1 || done_cycle != pix_last_cycle + 1 || busy[1] !== 1'b0) begin
         fails++;
         $display("FAIL k1_done: cnt=%0d at cyc %0d busy=%b, want 1 at %0d busy 0",
                  done_cnt, done_cycle, busy[1], pix_last_cycle + 1);
      end else passed++;
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         start[s]   = 1'b0;
         abort[s]   = 1'b0;
         s_valid[s] = 1'b0;
         s_data[s]  = 8'd0;
      end
      test_reset;
      test_basic;
      test_backpressure;
      test_abort;
      test_reset_flush;
      test_ignored_start_k1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
